// File: rtl/down_counter.sv
// -----------------------------------------------------------------------------
// down_counter
//
// Free-running WIDTH-bit down counter. It decrements on every rising edge of
// clk and wraps from 0 back to all-ones. A synchronous reset loads RESET_VALUE.
//
// Parameters
//   WIDTH       : counter width in bits (2..32)
//   RESET_VALUE : value loaded while reset is sampled high (must fit in WIDTH)
//
// Ports
//   clk     : single clock; all state updates on the rising edge
//   reset   : synchronous, active-high reset
//   counter : current count, driven straight from the state register
// -----------------------------------------------------------------------------
module down_counter #(
    parameter int                 WIDTH       = 4,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] counter
);

    logic [WIDTH-1:0] counter_reg;
    logic [WIDTH-1:0] counter_next;

    // Unsigned WIDTH-bit decrement; the borrow out of the top bit is dropped,
    // so 0 naturally rolls over to all-ones with no special case.
    always_comb begin
        counter_next = counter_reg - WIDTH'(1);
    end

    // Reset is only looked at on the clock edge, so a pulse that rises and
    // falls between edges never reaches the register.
    always_ff @(posedge clk) begin
        if (reset) begin
            counter_reg <= RESET_VALUE;
        end else begin
            counter_reg <= counter_next;
        end
    end

    assign counter = counter_reg;

endmodule

// File: tb/tb_down_counter.sv
// -----------------------------------------------------------------------------
// tb_down_counter
//
// Runs two down_counter instances side by side from a shared clock and reset:
// the default 4-bit build and an 8-bit build with RESET_VALUE = 8'h10.
// The stimulus process chooses reset (and optional between-edge glitches),
// computes the expected counts with modular arithmetic and pushes them into a
// queue; a separate monitor pops one entry per rising edge and compares.
// -----------------------------------------------------------------------------
module tb_down_counter;

    localparam int          W_A  = 4;
    localparam int          W_B  = 8;
    localparam logic [3:0]  RV_A = 4'hF;
    localparam logic [7:0]  RV_B = 8'h10;

    logic       clk;
    logic       reset;
    logic [3:0] counter_a;
    logic [7:0] counter_b;

    typedef struct {
        logic [3:0] exp_a;
        logic [7:0] exp_b;
        logic       rst;
        int         seq;
    } exp_t;

    exp_t exp_q[$];

    int  checks   = 0;
    int  failures = 0;
    int  seq_no   = 0;
    bit  done     = 0;
    bit  started  = 0;
    int  wraps_a  = 0;
    int  wraps_b  = 0;

    // Reference state: plain integers, reduced modulo 2^WIDTH.
    int model_a;
    int model_b;

    down_counter dut_a (
        .clk     (clk),
        .reset   (reset),
        .counter (counter_a)
    );

    down_counter #(
        .WIDTH       (W_B),
        .RESET_VALUE (RV_B)
    ) dut_b (
        .clk     (clk),
        .reset   (reset),
        .counter (counter_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compute what both counters must hold after the next rising edge.
    task automatic push_expect(input bit r);
        exp_t e;
        if (r) begin
            model_a = int'(RV_A);
            model_b = int'(RV_B);
        end else begin
            model_a = (model_a + (1 << W_A) - 1) % (1 << W_A);
            model_b = (model_b + (1 << W_B) - 1) % (1 << W_B);
        end
        e.exp_a = model_a[3:0];
        e.exp_b = model_b[7:0];
        e.rst   = r;
        e.seq   = seq_no;
        seq_no++;
        exp_q.push_back(e);
    endtask

    // One cycle of stimulus: drive reset at the falling edge, optionally
    // throw a 2 ns reset glitch that is gone before the rising edge.
    task automatic step(input bit r, input bit glitch);
        @(negedge clk);
        reset = r;
        push_expect(r);
        if (glitch && !r) begin
            #1 reset = 1'b1;
            #2 reset = 1'b0;
        end
    endtask

    // Monitor: one comparison per rising edge, sampled 1 ns after the edge.
    initial begin
        exp_t e;
        int   prev_a;
        int   prev_b;
        prev_a = -1;
        prev_b = -1;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if ($isunknown(counter_a) || counter_a !== e.exp_a) begin
                    failures++;
                    $display("FAIL cnt4 seq=%0d rst=%0b actual=%h required=%h",
                             e.seq, e.rst, counter_a, e.exp_a);
                end
                checks++;
                if ($isunknown(counter_b) || counter_b !== e.exp_b) begin
                    failures++;
                    $display("FAIL cnt8 seq=%0d rst=%0b actual=%h required=%h",
                             e.seq, e.rst, counter_b, e.exp_b);
                end
                if (!e.rst && prev_a == 0 && e.exp_a == 4'hF) wraps_a++;
                if (!e.rst && prev_b == 0 && e.exp_b == 8'hFF) wraps_b++;
                prev_a = int'(e.exp_a);
                prev_b = int'(e.exp_b);
                $display("txn seq=%0d rst=%0b cnt4=%h cnt8=%h",
                         e.seq, e.rst, counter_a, counter_b);
            end else if (started && !done) begin
                checks++;
                failures++;
                $display("FAIL sb_empty actual=empty required=entry");
            end
        end
    end

    initial begin
        int guard;
        model_a = 0;
        model_b = 0;

        // Power-up: reset high for the first two rising edges.
        reset = 1'b1;
        push_expect(1'b1);
        started = 1'b1;
        step(1'b1, 1'b0);

        // Free count well past several 4-bit wraps and one 8-bit wrap.
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0);

        // Reset for one edge exactly when the 4-bit counter holds 7.
        guard = 0;
        while (model_a != 7 && guard < 32) begin
            step(1'b0, 1'b0);
            guard++;
        end
        checks++;
        if (model_a != 7) begin
            failures++;
            $display("FAIL mid_reset_setup actual=%0d required=7", model_a);
        end
        step(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

        // Between-edge reset glitches must not disturb the count.
        for (int i = 0; i < 20; i++) step(1'b0, (i % 2) == 0);

        // Randomised mix of resets, glitches and free running.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
        end

        // Long reset hold, release, then long run covering 8-bit wrap.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 280; i++) step(1'b0, 1'b0);

        // Drain the scoreboard with a bounded wait.
        done = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain actual=%0d required=0", exp_q.size());
        end

        // Both wrap transitions must have been observed in sequence.
        checks++;
        if (wraps_a < 2) begin
            failures++;
            $display("FAIL wrap4_seen actual=%0d required>=2", wraps_a);
        end
        checks++;
        if (wraps_b < 1) begin
            failures++;
            $display("FAIL wrap8_seen actual=%0d required>=1", wraps_b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/down_counter.md
DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits; legal range 2..32.
REQ-002 Parameter RESET_VALUE, default {WIDTH{1'b1}} (4'hF): value loaded on reset; SHALL fit in WIDTH bits.
REQ-003 Port clk, input, 1 bit: single clock; all state SHALL update on the rising edge only.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port counter, output, WIDTH bits: current count, driven directly from a register.
REQ-006 Port order SHALL be clk, reset, counter, so that positional instantiation down_counter(clk, reset, counter) connects correctly.
REQ-007 The block SHALL have no other ports.

Function
REQ-008 On every rising clk edge with reset=0, counter SHALL load counter-1 modulo 2^WIDTH.
REQ-009 Wrap-around: when counter=0 and reset=0, the next edge SHALL load {WIDTH{1'b1}} (4'hF at default).
REQ-010 The counter SHALL decrement every cycle; there is no enable, load or hold input.
REQ-011 counter SHALL change only on rising clk edges; there SHALL be no combinational path from reset to counter.
REQ-012 Latency: a change on reset SHALL take effect at the first rising edge that samples it; counter is valid in the cycle after that edge.
REQ-013 Count sequence at defaults after reset release: F, E, D, ..., 1, 0, F, ...; period is 2^WIDTH cycles.
REQ-014 Arithmetic SHALL be unsigned, WIDTH bits, with borrow discarded; no saturation.
REQ-015 Before the first reset edge, counter is X in simulation; the block SHALL NOT depend on an initial value.

Reset
REQ-016 When reset=1 at a rising clk edge, counter SHALL load RESET_VALUE (4'hF at default), regardless of its current value.
REQ-017 Reset mid-count: asserting reset at any count SHALL force RESET_VALUE on the next edge and hold it for as long as reset stays high.
REQ-018 Release: on the first edge with reset=0 after reset, counter SHALL load RESET_VALUE-1 (4'hE at default).
REQ-019 Reset that toggles between clock edges without being sampled high at an edge SHALL have no effect.

Verification
REQ-020 Power-up: clk period 10 ns, reset=1 for the first 20 ns (two rising edges) -> counter=4'hF after the first edge and still 4'hF after the second.
REQ-021 Free count: after reset release -> counter reads E, D, ..., 0 on successive edges, then 4'hF on the 16th edge after release, and the sequence repeats.
REQ-022 Wrap: observe counter=0 followed by counter=4'hF on the next edge, with no intermediate value and no X.
REQ-023 Mid-count reset: assert reset for one edge while counter=4'h7 -> counter=4'hF at that edge, then 4'hE on the next edge.
REQ-024 Glitch immunity: pulse reset high for 2 ns between edges -> the count sequence continues uninterrupted.
REQ-025 Parameters: WIDTH=8, RESET_VALUE=8'h10 -> after reset, counter reads 10, 0F, ..., 00, FF, FE, and so on.
